// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive buffer: receiver state encoding
// and default build constants.
package uart_rx_pkg;

  localparam int BAUD_DIV_DEF = 174;
  localparam int FIFO_AW_DEF  = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    WAIT_HI = 3'd4
  } rx_state_e;

endpackage

// File: rtl/ice_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. A push into a full FIFO only
// succeeds when a pop happens in the same cycle.
module ice_sync_fifo #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] pop_data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] mem_q [2**AW];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          wr_en;
  logic          rd_en;

  assign full_o     = (count_q == DEPTH);
  assign empty_o    = (count_q == {(AW+1){1'b0}});
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  // A simultaneous pop frees the slot the push needs.
  assign rd_en = pop_i && !empty_o;
  assign wr_en = push_i && (!full_o || rd_en);

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1'b1);
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + AW'(1'b1);
      end
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + (AW+1)'(1'b1);
        2'b01:   count_q <= count_q - (AW+1)'(1'b1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_buf.sv
// 8N1 UART receiver with line synchronizer, mid-bit sampling FSM and a
// receive FIFO; framing errors and dropped bytes are reported as pulses.
module uart_rx_buf
  import uart_rx_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF,
  parameter int FIFO_AW  = FIFO_AW_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx,
  output logic [7:0]         rd_data,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic               frame_err,
  output logic               overflow,
  output logic [FIFO_AW:0]   fill
);

  localparam int          CW      = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF_LD = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LD = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          sync1_q, rxs_q, rxs_prev_q;
  logic          frame_err_q, frame_err_d;
  logic          overflow_q, overflow_d;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;

  assign rd_valid  = !fifo_empty;
  assign pop       = rd_valid && rd_ready;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

  // Synchronizer plus one extra stage for falling-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync1_q    <= rx;
      rxs_q      <= sync1_q;
      rxs_prev_q <= rxs_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= {CW{1'b0}};
      idx_q       <= 3'd0;
      shift_q     <= 8'h00;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rxs_prev_q && !rxs_q) begin
          state_d = START;
          cnt_d   = HALF_LD;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (cnt_q == {CW{1'b0}}) begin
          // A line that is high again at mid start bit was only a glitch.
          if (!rxs_q) begin
            state_d = DATA;
            cnt_d   = FULL_LD;
            idx_d   = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_q == {CW{1'b0}}) begin
          shift_d = {rxs_q, shift_q[7:1]};
          cnt_d   = FULL_LD;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            state_d = DATA;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      STOP: begin
        if (cnt_q == {CW{1'b0}}) begin
          if (rxs_q) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HI;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      WAIT_HI: begin
        if (rxs_q) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_HI;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    overflow_d = push && fifo_full && !pop;
  end

  ice_sync_fifo #(
    .DW (8),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (reset),
    .push_i      (push),
    .push_data_i (shift_q),
    .pop_i       (pop),
    .pop_data_o  (rd_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fill)
  );

endmodule

// File: tb/tb_uart_rx_buf.sv
// Directed bench for uart_rx_buf at BAUD_DIV=16, FIFO_AW=3; inputs change and
// outputs are checked 1 time unit after the rising edge.
module tb_uart_rx_buf;
  import uart_rx_pkg::*;

  localparam int BD = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx;
  logic          rd_ready;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic          frame_err;
  logic          overflow;
  logic [AW:0]   fill;

  int            n_checks = 0;
  int            n_errors = 0;
  int            fe_cnt   = 0;
  int            ov_cnt   = 0;
  int            fe_base;
  int            ov_base;
  logic [7:0]    pq [$];

  always #5 clk = ~clk;

  uart_rx_buf #(
    .BAUD_DIV (BD),
    .FIFO_AW  (AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .frame_err (frame_err),
    .overflow  (overflow),
    .fill      (fill)
  );

  // Pulse counters and pop log, sampled mid-cycle before the popping edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_err) fe_cnt++;
      if (overflow) ov_cnt++;
      if (rd_valid && rd_ready) pq.push_back(rd_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Start bit, 8 data bits LSB first, then the stop level held nstop cycles.
  task automatic send_bits(input logic [7:0] b, input logic stop, input int nstop);
    rx = 1'b0;
    tick(BD);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(BD);
    end
    rx = stop;
    tick(nstop);
  endtask

  initial begin
    logic [7:0] v5a;
    v5a      = 8'h5A;
    reset    = 1'b1;
    rx       = 1'b1;
    rd_ready = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(2);
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_fill", 32'(fill), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));

    // Single byte: visible exactly one cycle after the stop-bit sample.
    rd_ready = 1'b1;
    send_bits(8'hA5, 1'b1, 10);
    check("t1_pre_valid", 32'(rd_valid), 32'd0);
    tick(1);
    check("t1_valid", 32'(rd_valid), 32'd1);
    check("t1_data", 32'(rd_data), 32'hA5);
    tick(1);
    check("t1_post_valid", 32'(rd_valid), 32'd0);
    tick(10);
    check("t1_ferr", 32'(fe_cnt), 32'd0);
    check("t1_pops", 32'(pq.size()), 32'd1);

    // Short low glitch on the idle line.
    pq.delete();
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(30);
    check("t2_fill", 32'(fill), 32'd0);
    check("t2_state", 32'(dut.state_q), 32'(IDLE));
    check("t2_pops", 32'(pq.size()), 32'd0);

    // Bad stop bit followed by a long break, then a clean byte.
    fe_base = fe_cnt;
    send_bits(8'h3C, 1'b0, BD);
    tick(40);
    rx = 1'b1;
    tick(20);
    check("t3_ferr_once", 32'(fe_cnt - fe_base), 32'd1);
    check("t3_fill", 32'(fill), 32'd0);
    check("t3_no_pop", 32'(pq.size()), 32'd0);
    send_bits(8'h11, 1'b1, BD);
    tick(5);
    check("t3_next_cnt", 32'(pq.size()), 32'd1);
    check("t3_next_data", 32'(pq[0]), 32'h11);
    check("t3_ferr_total", 32'(fe_cnt - fe_base), 32'd1);

    // Nine bytes into an 8-deep FIFO with no consumer.
    rd_ready = 1'b0;
    ov_base  = ov_cnt;
    for (int b = 0; b < 9; b++) begin
      send_bits(8'(b), 1'b1, BD);
    end
    tick(2);
    check("t4_fill", 32'(fill), 32'd8);
    check("t4_ovf_once", 32'(ov_cnt - ov_base), 32'd1);
    check("t4_head", 32'(rd_data), 32'h00);
    pq.delete();
    rd_ready = 1'b1;
    tick(12);
    rd_ready = 1'b0;
    check("t4_drain_cnt", 32'(pq.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t4_drain_%0d", i), 32'(pq[i]), 32'(i));
    end
    check("t4_fill_empty", 32'(fill), 32'd0);

    // Full FIFO with a pop landing on the same edge as the ninth push.
    for (int b = 0; b < 8; b++) begin
      send_bits(8'h20 + 8'(b), 1'b1, BD);
    end
    check("t5_full", 32'(fill), 32'd8);
    ov_base = ov_cnt;
    pq.delete();
    send_bits(8'h08, 1'b1, 10);
    rd_ready = 1'b1;
    tick(1);
    rd_ready = 1'b0;
    check("t5_fill_same", 32'(fill), 32'd8);
    tick(8);
    check("t5_no_ovf", 32'(ov_cnt - ov_base), 32'd0);
    rd_ready = 1'b1;
    tick(12);
    rd_ready = 1'b0;
    check("t5_pop_cnt", 32'(pq.size()), 32'd9);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t5_out_%0d", i), 32'(pq[i]), 32'h20 + 32'(i));
    end
    check("t5_last", 32'(pq[8]), 32'h08);

    // Reset in the middle of data bit 4 with one byte already buffered.
    send_bits(8'h77, 1'b1, BD);
    tick(2);
    check("t6_pre_fill", 32'(fill), 32'd1);
    rx = 1'b0;
    tick(BD);
    for (int i = 0; i < 4; i++) begin
      rx = v5a[i];
      tick(BD);
    end
    rx = v5a[4];
    tick(8);
    check("t6_in_data", 32'(dut.state_q), 32'(DATA));
    check("t6_idx", 32'(dut.idx_q), 32'd4);
    reset = 1'b1;
    #1;
    check("t6_rst_fill", 32'(fill), 32'd0);
    check("t6_rst_valid", 32'(rd_valid), 32'd0);
    check("t6_rst_state", 32'(dut.state_q), 32'(IDLE));
    check("t6_rst_ferr", 32'(frame_err), 32'd0);
    check("t6_rst_ovf", 32'(overflow), 32'd0);
    rx = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(40);
    check("t6_no_push", 32'(fill), 32'd0);
    pq.delete();
    rd_ready = 1'b1;
    send_bits(8'h5A, 1'b1, BD);
    tick(3);
    check("t6_next_cnt", 32'(pq.size()), 32'd1);
    check("t6_next_data", 32'(pq[0]), 32'h5A);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_buf.md
UART_RX_BUF -- requirements
Module: uart_rx_buf

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 174, meaning clk cycles per UART bit (minimum 8).
REQ-002 SHALL have parameter FIFO_AW, default 3, meaning log2 of the receive FIFO depth (depth 8).
REQ-003 SHALL have port clk  input  1  system clock; the only clock in the block.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port rx  input  1  asynchronous serial line from the host USB bridge, idle high.
REQ-006 SHALL have port rd_data  output  8  byte at the FIFO head.
REQ-007 SHALL have port rd_valid  output  1  FIFO non-empty; rd_data is valid.
REQ-008 SHALL have port rd_ready  input  1  consumer accepts the head byte.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-010 SHALL have port overflow  output  1  one-cycle pulse when a received byte is dropped because the FIFO is full.
REQ-011 SHALL have port fill  output  FIFO_AW+1  number of bytes currently held.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer with both flops resetting to 1; all decoding uses the synchronized value rxs.
REQ-013 SHALL implement the states IDLE, START, DATA, STOP and WAIT_HI, plus a bit counter cnt and a bit index idx[2:0].
REQ-014 IDLE: on rxs transitioning 1->0, SHALL go to START and load cnt = BAUD_DIV/2 - 1 (integer divide).
REQ-015 START: SHALL decrement cnt; at cnt==0, if rxs==0 go to DATA with cnt=BAUD_DIV-1 and idx=0, else (glitch) return to IDLE with no output.
REQ-016 DATA: at cnt==0 SHALL shift rxs into the shift register, LSB first, and reload cnt=BAUD_DIV-1; after idx==7 is sampled, go to STOP.
REQ-017 STOP: at cnt==0, if rxs==1 SHALL push the byte and go to IDLE; if rxs==0 it SHALL pulse frame_err for one cycle, discard the byte and go to WAIT_HI.
REQ-018 WAIT_HI: SHALL remain until rxs==1, then go to IDLE (a break condition produces exactly one frame_err).
REQ-019 FIFO SHALL be first-word fall-through: rd_valid = (fill != 0) and rd_data = mem[rd_ptr], both combinational from registers.
REQ-020 Pop SHALL occur on rd_valid && rd_ready; rd_ready while empty SHALL be ignored.
REQ-021 A pushed byte SHALL appear on rd_valid/rd_data on the cycle after the stop-bit sample cycle.
REQ-022 Push while full with no pop in the same cycle SHALL drop the new byte, leave FIFO contents unchanged and pulse overflow for one cycle.
REQ-023 Push and pop in the same cycle (including when full) SHALL both succeed, with fill unchanged.
REQ-024 Pointers SHALL be FIFO_AW bits wide and wrap modulo the depth; fill SHALL range 0..2^FIFO_AW.

Reset
REQ-025 Asserting reset SHALL immediately set state=IDLE, cnt=0, idx=0, the shift register to 0, pointers to 0, fill=0, rd_valid=0, frame_err=0, overflow=0, and synchronizer flops to 1.
REQ-026 Reset asserted mid-frame SHALL abandon the frame with no push; after release the block SHALL wait for a fresh 1->0 edge.
REQ-027 FIFO memory contents need not be reset; rd_data is don't-care while rd_valid==0.

Structure
REQ-028 Shared package uart_rx_pkg SHALL hold the state enumeration and the default constants BAUD_DIV_DEF=174 and FIFO_AW_DEF=3.
REQ-029 The FIFO SHALL be one sub-module, ice_sync_fifo (parameters DW=8 and AW, with push, pop, full, empty and count), reusable elsewhere in ice_bus.
REQ-030 The top level SHALL contain the synchronizer, the receive FSM and the pulse registers only.

Verification (BAUD_DIV=16, FIFO_AW=3)
REQ-031 Send 0xA5 (8N1), rd_ready=1 -> a single rd_valid beat with rd_data=0xA5, 1 cycle after the stop-bit sample; frame_err=0.
REQ-032 Send a 3-cycle low glitch on idle rx -> no push, FSM back in IDLE, fill=0.
REQ-033 Send 0x3C with stop bit=0, then hold rx low for 40 cycles, then high -> exactly one frame_err pulse, fill=0, and the next byte 0x11 is received correctly.
REQ-034 With rd_ready=0, send 9 bytes 0x00..0x08 -> fill=8, one overflow pulse on the 9th byte, then drain yields 0x00..0x07 in order.
REQ-035 With FIFO full, hold rd_ready=1 so a pop coincides with the 9th byte's push -> no overflow, fill stays 8, 0x08 is last out.
REQ-036 Assert reset during DATA bit 4 of a frame -> all outputs at reset values, no push; the next complete frame 0x5A is received correctly.
